// File: rtl/gfx_cmd_queue.sv
// gfx_cmd_queue: FIFO of fill/blit commands between the host and GraphicsCard.
// Issues one start pulse per command while the engine is idle, then tracks the
// engine's busy handshake (ack timeout, completion) and sticky error flags.
// Optional: define GFX_CMD_STATS_EN to add saturating issued/dropped counters.
module gfx_cmd_queue #(
  parameter int unsigned XW          = 9,
  parameter int unsigned YW          = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_op,
  input  logic                       cmd_fill_value,
  input  logic [XW-1:0]              cmd_x1,
  input  logic [YW-1:0]              cmd_y1,
  input  logic [XW-1:0]              cmd_x2,
  input  logic [YW-1:0]              cmd_y2,
  input  logic [XW-1:0]              cmd_w,
  input  logic [YW-1:0]              cmd_h,
  input  logic                       flush,
  input  logic                       err_clear,
  input  logic                       eng_busy,
  input  logic                       eng_error,
  output logic                       eng_start_fill,
  output logic                       eng_start_blit,
  output logic                       eng_fill_value,
  output logic [XW-1:0]              eng_x1,
  output logic [YW-1:0]              eng_y1,
  output logic [XW-1:0]              eng_x2,
  output logic [YW-1:0]              eng_y2,
  output logic [XW-1:0]              eng_w,
  output logic [YW-1:0]              eng_h,
  output logic [$clog2(DEPTH):0]     queue_level,
  output logic                       status,
  output logic                       err_sticky,
  output logic                       overflow
`ifdef GFX_CMD_STATS_EN
  ,
  output logic [15:0]                issued_cnt,
  output logic [15:0]                dropped_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE} state_t;

  typedef struct packed {
    logic          op;
    logic          fill;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
    logic [XW-1:0] x2;
    logic [YW-1:0] y2;
    logic [XW-1:0] w;
    logic [YW-1:0] h;
  } cmd_t;

  cmd_t            mem_q [DEPTH];
  cmd_t            cmd_in, head, opr_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full, push, drop, pop, timeout;
  logic            start_fill_q, start_blit_q, err_q, ovf_q;

  assign cmd_in = '{op: cmd_op, fill: cmd_fill_value, x1: cmd_x1, y1: cmd_y1,
                    x2: cmd_x2, y2: cmd_y2, w: cmd_w, h: cmd_h};
  assign head   = mem_q[rd_ptr_q];

  // Fullness uses only the registered level, so a same-cycle pop never makes room.
  assign full      = (level_q == LW'(DEPTH));
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full && !flush;
  assign drop      = cmd_valid && full && !flush;
  assign level_d   = flush ? '0 : (level_q + LW'(push) - LW'(pop));

  // Next-state logic for the issue/handshake FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((level_q != '0) && !eng_busy) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (eng_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!eng_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, ack counter, start pulses and popped operand registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      start_fill_q <= 1'b0;
      start_blit_q <= 1'b0;
      opr_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_fill_q <= pop && !head.op;
      start_blit_q <= pop && head.op;
      if (pop) opr_q <= head;
    end
  end

  // Queue storage and pointers; flush empties by aligning read to write pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (push) begin
        mem_q[wr_ptr_q] <= cmd_in;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (flush)    rd_ptr_q <= wr_ptr_q;
      else if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Sticky error/overflow flags; a set event beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (eng_error || timeout) err_q <= 1'b1;
      else if (err_clear)       err_q <= 1'b0;
      if (drop)                 ovf_q <= 1'b1;
      else if (err_clear)       ovf_q <= 1'b0;
    end
  end

`ifdef GFX_CMD_STATS_EN
  logic [15:0] issued_q, dropped_q;

  // Saturating statistics counters, cleared together with the error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued_q  <= '0;
      dropped_q <= '0;
    end else if (err_clear) begin
      issued_q  <= '0;
      dropped_q <= '0;
    end else begin
      if ((state_q == S_ISSUE) && (issued_q != '1)) issued_q  <= issued_q + 16'd1;
      if (drop && (dropped_q != '1))                dropped_q <= dropped_q + 16'd1;
    end
  end

  assign issued_cnt  = issued_q;
  assign dropped_cnt = dropped_q;
`endif

  assign eng_start_fill = start_fill_q;
  assign eng_start_blit = start_blit_q;
  assign eng_fill_value = opr_q.fill;
  assign eng_x1         = opr_q.x1;
  assign eng_y1         = opr_q.y1;
  assign eng_x2         = opr_q.x2;
  assign eng_y2         = opr_q.y2;
  assign eng_w          = opr_q.w;
  assign eng_h          = opr_q.h;
  assign queue_level    = level_q;
  assign status         = (level_q != '0) || (state_q != S_IDLE);
  assign err_sticky     = err_q;
  assign overflow       = ovf_q;

endmodule
